// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the pipelined MIPS core.
// Provides the fetch FSM state encoding, the datapath word width, the bubble
// instruction (sll $0,$0,0 encodes as all zeros) and the PC increment.
package fetch_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   load              - capture instr_in/pc_plus4_in as a valid instruction
//   flush             - replace the contents with a bubble (wins over load)
//   instr_in          - instruction word to capture
//   pc_plus4_in       - PC+4 of that instruction
//   instr, pc_plus4   - registered instruction and PC+4
//   valid             - 1 when the register holds a real instruction
// With neither load nor flush the register holds its value, which is how
// decode stalls freeze the stage.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_plus4_in,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
);

    // A bubble carries the NOP encoding and a zero PC+4 so that a flushed
    // entry looks identical to the post-reset contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake and feeds the IF/ID register that drives decode.
// Ports:
//   clk, reset_n           - clock and asynchronous active-low reset
//   imem_req, imem_addr    - fetch request and its address (state/register decoded)
//   imem_ack, imem_rdata   - memory response; data used only on req & ack
//   StallD                 - hazard unit stall of decode
//   PCSrcM, PCBranchM      - taken branch from MEM and its target
//   JumpD, PCJumpD         - jump in decode and its target
//   InstrD, PCPlus4D       - IF/ID instruction and PC+4
//   ValidD                 - IF/ID holds a real instruction
//   opD, functD            - opcode and funct fields for the controller
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              StallD,
    input  logic              PCSrcM,
    input  logic [WORD_W-1:0] PCBranchM,
    input  logic              JumpD,
    input  logic [WORD_W-1:0] PCJumpD,
    output logic [WORD_W-1:0] InstrD,
    output logic [WORD_W-1:0] PCPlus4D,
    output logic              ValidD,
    output logic [5:0]        opD,
    output logic [5:0]        functD
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [WORD_W-1:0] pcf;
    logic [WORD_W-1:0] pcf_next;
    logic [WORD_W-1:0] pcf_plus4;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] buf_instr;
    logic [WORD_W-1:0] buf_pc_plus4;
    logic              buf_load;
    logic              transfer;
    logic              take_branch;
    logic              take_jump;
    logic              redirect;
    logic [WORD_W-1:0] redirect_target;
    logic              ifid_load;
    logic              ifid_flush;
    logic [WORD_W-1:0] ifid_instr_in;
    logic [WORD_W-1:0] ifid_pc_in;

    // The memory-side outputs depend only on state and registers so that no
    // input ever reaches imem_req/imem_addr combinationally.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? addr_q : pcf;

    assign transfer  = imem_req & imem_ack;
    assign pcf_plus4 = pcf + PC_INC;

    // A branch resolved in MEM is older than anything in decode, so it wins
    // and ignores stalls; a jump only counts once its instruction leaves D.
    assign take_branch     = PCSrcM;
    assign take_jump       = JumpD & ~StallD & ~PCSrcM;
    assign redirect        = take_branch | take_jump;
    assign redirect_target = take_branch ? PCBranchM : PCJumpD;

    // State, PC, outstanding-request address and skid buffer.
    // addr_q follows PCF while fetching so that, if a redirect abandons an
    // unacked request, DRAIN keeps presenting the address the memory saw.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RST;
            pcf          <= RESET_PC;
            addr_q       <= RESET_PC;
            buf_instr    <= NOP_INSTR;
            buf_pc_plus4 <= '0;
        end else begin
            state <= state_next;
            pcf   <= pcf_next;
            if (state == FETCH) begin
                addr_q <= pcf;
            end
            if (buf_load) begin
                buf_instr    <= imem_rdata;
                buf_pc_plus4 <= pcf_plus4;
            end
        end
    end

    // Next-state, PC and IF/ID control.
    // A redirect always flushes IF/ID and drops the skid entry (leaving HELD
    // is enough to forget it). A request still in flight when the redirect
    // hits must be drained before new fetches, because the memory expects
    // its address to stay stable until acked.
    always_comb begin
        state_next    = state;
        pcf_next      = pcf;
        buf_load      = 1'b0;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_pc_in    = pcf_plus4;

        if (redirect) begin
            pcf_next   = redirect_target;
            ifid_flush = 1'b1;
            case (state)
                RST:     state_next = FETCH;
                FETCH:   state_next = transfer ? FETCH : DRAIN;
                HELD:    state_next = FETCH;
                DRAIN:   state_next = imem_ack ? FETCH : DRAIN;
                default: state_next = RST;
            endcase
        end else begin
            case (state)
                RST: begin
                    state_next = FETCH;
                    ifid_flush = ~StallD;
                end
                FETCH: begin
                    if (transfer) begin
                        pcf_next = pcf_plus4;
                        if (StallD) begin
                            buf_load   = 1'b1;
                            state_next = HELD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else begin
                        ifid_flush = ~StallD;
                    end
                end
                HELD: begin
                    if (!StallD) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = buf_instr;
                        ifid_pc_in    = buf_pc_plus4;
                        state_next    = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_next = FETCH;
                    end
                    ifid_flush = ~StallD;
                end
                default: state_next = RST;
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .instr_in    (ifid_instr_in),
        .pc_plus4_in (ifid_pc_in),
        .instr       (InstrD),
        .pc_plus4    (PCPlus4D),
        .valid       (ValidD)
    );

    assign opD    = InstrD[31:26];
    assign functD = InstrD[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage. A queue-based model of the
// fetch stream (next PC, skid entries, abandoned requests) predicts every
// output each cycle; a short directed prologue walks the PC wrap, a stall,
// a branch into a drain, a reset in the middle of that drain and the
// jump/branch priority cases before random traffic takes over.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        StallD;
    logic        PCSrcM;
    logic [31:0] PCBranchM;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [5:0]  opD;
    logic [5:0]  functD;

    int checks   = 0;
    int failures = 0;

    bit          mStarted;
    logic [31:0] mPc;
    word_t       mSkid[$];
    logic [31:0] mAbandoned[$];
    logic [31:0] mInstr;
    logic [31:0] mPcp4;
    logic        mValid;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    always #5 clk = ~clk;

    // Memory returns a word derived from the address it is asked for.
    assign imem_rdata = imem_ack ? memWord(imem_addr) : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .StallD     (StallD),
        .PCSrcM     (PCSrcM),
        .PCBranchM  (PCBranchM),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .opD        (opD),
        .functD     (functD)
    );

    // Request is up once started, unless a word is parked waiting for decode;
    // an abandoned request always keeps it up.
    function automatic logic expReq();
        return mStarted && (mAbandoned.size() > 0 || mSkid.size() == 0);
    endfunction

    function automatic logic [31:0] expAddr();
        return (mAbandoned.size() > 0) ? mAbandoned[0] : mPc;
    endfunction

    task automatic modelBubble();
        mInstr = 32'h0;
        mPcp4  = 32'h0;
        mValid = 1'b0;
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        mPc      = RST_PC;
        mSkid.delete();
        mAbandoned.delete();
        modelBubble();
    endtask

    task automatic modelLoad(input word_t w);
        mInstr = w.instr;
        mPcp4  = w.pcp4;
        mValid = 1'b1;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic modelStep();
        logic  req;
        logic  done;
        logic  br;
        logic  jp;
        word_t w;
        req  = expReq();
        done = req && imem_ack;
        br   = PCSrcM;
        jp   = JumpD && !StallD && !PCSrcM;
        if (!mStarted) begin
            mStarted = 1'b1;
            if (br || jp) begin
                mPc = br ? PCBranchM : PCJumpD;
                modelBubble();
            end else if (!StallD) begin
                modelBubble();
            end
        end else if (br || jp) begin
            if (mAbandoned.size() > 0) begin
                if (done) void'(mAbandoned.pop_front());
            end else if (req && !done) begin
                mAbandoned.push_back(mPc);
            end
            mSkid.delete();
            mPc = br ? PCBranchM : PCJumpD;
            modelBubble();
        end else if (mAbandoned.size() > 0) begin
            if (done) void'(mAbandoned.pop_front());
            if (!StallD) modelBubble();
        end else if (mSkid.size() > 0) begin
            if (!StallD) begin
                w = mSkid.pop_front();
                modelLoad(w);
            end
        end else if (done) begin
            w.instr = memWord(mPc);
            w.pcp4  = mPc + 32'd4;
            mPc     = mPc + 32'd4;
            if (StallD) mSkid.push_back(w);
            else modelLoad(w);
        end else if (!StallD) begin
            modelBubble();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string ph);
        checkOutput({ph, ".imem_req"},  {31'b0, imem_req}, {31'b0, expReq()});
        checkOutput({ph, ".imem_addr"}, imem_addr, expAddr());
        checkOutput({ph, ".InstrD"},    InstrD, mInstr);
        checkOutput({ph, ".PCPlus4D"},  PCPlus4D, mPcp4);
        checkOutput({ph, ".ValidD"},    {31'b0, ValidD}, {31'b0, mValid});
        checkOutput({ph, ".opD"},       {26'b0, opD}, {26'b0, mInstr[31:26]});
        checkOutput({ph, ".functD"},    {26'b0, functD}, {26'b0, mInstr[5:0]});
    endtask

    task automatic applyStimulus(input logic s, input logic br, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic a);
        StallD    = s;
        PCSrcM    = br;
        PCBranchM = bt;
        JumpD     = j;
        PCJumpD   = jt;
        imem_ack  = a;
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        case ($urandom % 4)
            0:       t = 32'hFFFF_FFFC;
            1:       t = $urandom;
            default: t = $urandom & 32'h0000_0FFC;
        endcase
        return t;
    endfunction

    initial begin
        bit doReset;
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        checkAll("reset");
        reset_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            doReset = 1'b0;
            case (cyc)
                0, 1, 2, 3: applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
                4, 5, 6:    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
                7:          applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
                8:          applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
                9: begin
                    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
                    doReset = 1'b1;
                end
                10:         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
                11:         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
                12:         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
                13:         applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
                14:         applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1);
                default: begin
                    if (!mStarted) begin
                        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
                    end else begin
                        applyStimulus(($urandom % 4) == 0, ($urandom % 12) == 0, randTarget(),
                                      ($urandom % 10) == 0, randTarget(), ($urandom % 3) != 0);
                    end
                    doReset = (($urandom % 150) == 0);
                end
            endcase

            if (doReset) begin
                #2 reset_n = 1'b0;
                #1;
                modelReset();
                checkAll("async_reset");
                #2 reset_n = 1'b1;
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            end

            @(posedge clk);
            modelStep();
            #1;
            checkAll("cycle");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode-stage controller. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and holds the IF/ID pipeline register, including `op`/`funct`, which feed the controller. It applies decode stalls from the hazard logic and redirects from taken branches (`PCSrcM`) and jumps.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request, held high until acknowledged.
- `imem_addr` output 32: fetch address; stable while `imem_req`=1 and no ack has been received.
- `imem_ack` input 1: response valid this cycle; a transfer completes when `imem_req` & `imem_ack`.
- `imem_rdata` input 32: instruction word; sampled only on a completed transfer.
- `StallD` input 1: hazard unit; hold IF/ID and do not advance the PC.
- `PCSrcM` input 1: taken branch in MEM.
- `PCBranchM` input 32: branch target.
- `JumpD` input 1: jump in decode.
- `PCJumpD` input 32: jump target.
- `InstrD` output 32: IF/ID instruction.
- `PCPlus4D` output 32: IF/ID PC+4.
- `ValidD` output 1: IF/ID holds a real instruction; 0 means bubble, and `InstrD` is then 0 (sll NOP).
- `opD` output 6: `InstrD[31:26]`, to the controller.
- `functD` output 6: `InstrD[5:0]`, to the controller.

## Operation
- Registers: `PCF` (next fetch address), `addr_q` (address of the outstanding request), `buf_q` (one-entry skid for instruction and PC+4), state, and IF/ID.
- States:
  - RST: reset state, `imem_req`=0. Goes to FETCH on the first clock after reset release.
  - FETCH: `imem_req`=1, `imem_addr`=`PCF`.
    - On a completed transfer with `StallD`=0: IF/ID loads {`imem_rdata`, `PCF`+4, valid}, `PCF`+=4, stay in FETCH.
    - On a completed transfer with `StallD`=1: `buf_q` loads the word and `PCF`+4, `PCF`+=4, go to HELD.
    - No transfer with `StallD`=0: IF/ID loads a bubble.
  - HELD: `imem_req`=0. When `StallD`=0, IF/ID loads from `buf_q`, go to FETCH.
  - DRAIN: `imem_req`=1, `imem_addr`=`addr_q`. Waits for the ack of the abandoned request and discards the data, then goes to FETCH, which fetches the already-updated `PCF`.
- Redirect rules:
  - `PCSrcM` has priority, is honoured regardless of `StallD`, and targets `PCBranchM`.
  - `JumpD` is honoured only when `StallD`=0 and `PCSrcM`=0, and targets `PCJumpD`.
- On a redirect:
  - `PCF` loads the target.
  - `buf_q` is discarded.
  - IF/ID loads a bubble. For `JumpD`, the jump instruction itself is leaving D, so this only drops the next fetch.
  - Next state:
    - DRAIN, if in FETCH with `imem_req`=1 and `imem_ack`=0; `addr_q` keeps the old address.
    - FETCH, if in FETCH and the ack arrived the same cycle; that data is discarded.
    - FETCH, from HELD.
- Arithmetic: PC+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0). Low two bits of targets are passed through unchecked.
- `StallD`=1 with no redirect: IF/ID holds its value exactly.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `InstrD`=0, `PCPlus4D`=0, `ValidD`=0, `opD`=0, `functD`=0, state=RST, `PCF`=`RESET_PC`.
- Fetch latency: a word acked in cycle N appears in IF/ID in cycle N+1. With a zero-wait memory (`imem_ack` tied high) throughput is one instruction per cycle.
- Branch penalty: a redirect in cycle N drives `imem_addr`=target in cycle N+1, unless draining.
- Reset asserted mid-operation (any state, request outstanding): immediate return to reset values. The memory must tolerate the abandoned request.
- All outputs are registered, except that `imem_req`/`imem_addr` decode from state and registers only (no input-to-output combinational path).

## Structure
- Shared pipeline package: state enum {RST, FETCH, HELD, DRAIN}, `NOP_INSTR`=32'h0, `PC_INC`=4, and the 32-bit word width.
- One natural sub-module: `ifid_reg`, the IF/ID register with load, hold, and flush-to-bubble controls. The PC/FSM logic stays in `fetch_stage`.

## Test plan
- Reset, then `imem_ack`=1 returning addr+32'h1000: `imem_addr` sequence 0,4,8; `InstrD`=32'h1000,32'h1004 one cycle later; `PCPlus4D`=4,8.
- `StallD`=1 for 3 cycles after the ack of addr 8: state HELD, `imem_req`=0, IF/ID frozen. On release, `InstrD`=word@8, then the fetch of 12.
- `PCSrcM`=1, `PCBranchM`=32'h40, while a request to 16 is unacked for 2 more cycles: DRAIN keeps `imem_addr`=16, ack data is dropped, next `imem_addr`=32'h40, no word@16 ever reaches D.
- `JumpD`=1 with `StallD`=1: ignored. Then `JumpD`=1 with `StallD`=0, `PCJumpD`=32'h80: `ValidD`=0 next cycle, `imem_addr`=32'h80.
- `PCSrcM` and `JumpD` in the same cycle: `PCBranchM` wins.
- `RESET_PC`=32'hFFFF_FFFC: after the first fetch `imem_addr`=0 and `PCPlus4D`=0. `reset_n` low mid-DRAIN: all outputs are at reset values in the same cycle.
